// File: rtl/stream_pool_pkg.sv
// stream_pool_pkg: shared types for the 2x2 stride-2 stream pooler
package stream_pool_pkg;
    typedef enum logic {ROW_TOP, ROW_BOT} state_e;
    localparam logic POOL_MAX = 1'b0;
    localparam logic POOL_AVG = 1'b1;
endpackage

// File: rtl/stream_pool2x2_pool4_reduce.sv
// pool4_reduce: combinational 4-pixel reduction (max; rounded average when STREAM_POOL_AVG_EN is defined)
module pool4_reduce
    import stream_pool_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] p0,
    input  logic [DATA_W-1:0] p1,
    input  logic [DATA_W-1:0] p2,
    input  logic [DATA_W-1:0] p3,
`ifdef STREAM_POOL_AVG_EN
    input  logic              mode,
`endif
    output logic [DATA_W-1:0] y
);
    logic [DATA_W-1:0] m01, m23, mx;
    assign m01 = p0 > p1 ? p0 : p1;
    assign m23 = p2 > p3 ? p2 : p3;
    assign mx  = m01 > m23 ? m01 : m23;
`ifdef STREAM_POOL_AVG_EN
    logic [DATA_W+1:0] sum;
    assign sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3} + (DATA_W+2)'(2);
    assign y   = mode == POOL_AVG ? DATA_W'(sum >> 2) : mx;
`else
    assign y = mx;
`endif
endmodule

// File: rtl/stream_pool2x2.sv
// stream_pool2x2: streaming 2x2 stride-2 pooling of raster pixels; STREAM_POOL_AVG_EN adds pool_mode (average)
module stream_pool2x2
    import stream_pool_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
`ifdef STREAM_POOL_AVG_EN
    input  logic              pool_mode,
`endif
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);
    localparam int CW = IMG_W > 2 ? $clog2(IMG_W) : 1;
    localparam int RW = IMG_H > 2 ? $clog2(IMG_H) : 1;

    if (IMG_W % 2 != 0 || IMG_W < 2) begin : g_bad_w
        $fatal(1, "stream_pool2x2: IMG_W must be even and >= 2");
    end
    if (IMG_H % 2 != 0 || IMG_H < 2) begin : g_bad_h
        $fatal(1, "stream_pool2x2: IMG_H must be even and >= 2");
    end

    state_e            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] linebuf_q [IMG_W];
    logic [DATA_W-1:0] linebuf_d [IMG_W];
    logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_W-1:0] out_data_q, out_data_d, red;
    logic              col_end, row_end;

    assign col_end = col_q == CW'(IMG_W - 1);
    assign row_end = row_q == RW'(IMG_H - 1);

    pool4_reduce #(.DATA_W(DATA_W)) u_reduce (
        .p0(linebuf_q[col_q ^ CW'(1)]),
        .p1(linebuf_q[col_q]),
        .p2(hold_q),
        .p3(in_data),
`ifdef STREAM_POOL_AVG_EN
        .mode(pool_mode),
`endif
        .y(red)
    );

    // next-state: advance counters and row parity, fill buffers, emit on bottom-right pixels
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        linebuf_d   = linebuf_q;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        out_data_d  = out_data_q;
        if (in_valid) begin
            col_d = col_end ? '0 : col_q + CW'(1);
            row_d = col_end ? (row_end ? '0 : row_q + RW'(1)) : row_q;
            if (col_end) state_d = state_q == ROW_TOP ? ROW_BOT : ROW_TOP;
            if (state_q == ROW_TOP) linebuf_d[col_q] = in_data;
            else if (!col_q[0]) hold_d = in_data;
            else begin
                out_valid_d = 1'b1;
                out_data_d  = red;
                out_last_d  = row_end && col_end;
            end
        end
    end

    // control and output registers, cleared by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ROW_TOP;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // pixel storage, left uninitialised on reset
    always_ff @(posedge clk) begin
        hold_q    <= hold_d;
        linebuf_q <= linebuf_d;
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
endmodule

// File: tb/tb_stream_pool2x2.sv
// tb_stream_pool2x2: directed self-checking bench for stream_pool2x2 at 4x4, 8-bit (avg tests when STREAM_POOL_AVG_EN)
module tb_stream_pool2x2;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       pool_mode = 1'b0;
    logic       out_valid, out_last;
    logic [7:0] out_data;
    int         errors = 0;
    int         checks = 0;
    int         nvalid = 0;
    logic [7:0] px [16];
    logic [7:0] ex [4];

    always #5 clk = ~clk;

    stream_pool2x2 #(.DATA_W(8), .IMG_W(4), .IMG_H(4)) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_data(in_data),
`ifdef STREAM_POOL_AVG_EN
        .pool_mode(pool_mode),
`endif
        .out_valid(out_valid),
        .out_data(out_data),
        .out_last(out_last)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic ev, input logic [7:0] ed, input logic el);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) nvalid++;
        check("out_valid", {7'd0, out_valid}, {7'd0, ev});
        check("out_last", {7'd0, out_last}, {7'd0, el});
        if (ev) check("out_data", out_data, ed);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_data  = 8'hxx;
        @(posedge clk);
        #1;
        check("idle_out_valid", {7'd0, out_valid}, 8'd0);
    endtask

    task automatic frame(input logic gaps);
        int k = 0;
        for (int i = 0; i < 16; i++) begin
            logic br;
            br = (i == 5) || (i == 7) || (i == 13) || (i == 15);
            push(px[i], br, br ? ex[k] : 8'd0, br && k == 3);
            if (br) k++;
            if (gaps) idle();
        end
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_valid", {7'd0, out_valid}, 8'd0);
        check("reset_data", out_data, 8'd0);
        check("reset_last", {7'd0, out_last}, 8'd0);
        reset = 1'b0;

        for (int i = 0; i < 16; i++) px[i] = 8'(i);
        ex = '{8'd5, 8'd7, 8'd13, 8'd15};
        frame(1'b0);
        idle();

        nvalid = 0;
        frame(1'b1);
        check("gap_count", 8'(nvalid), 8'd4);

        frame(1'b0);
        for (int i = 0; i < 16; i++) px[i] = 8'(15 - i);
        ex = '{8'd15, 8'd13, 8'd7, 8'd5};
        frame(1'b0);
        idle();
        check("hold_data", out_data, 8'd5);

        for (int i = 0; i < 10; i++) push(8'(i), i == 5 || i == 7, 8'(i), 1'b0);
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd99;
        @(posedge clk);
        #1;
        check("midreset_valid", {7'd0, out_valid}, 8'd0);
        check("midreset_data", out_data, 8'd0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) px[i] = 8'(i);
        ex = '{8'd5, 8'd7, 8'd13, 8'd15};
        frame(1'b0);

        px = '{8'd255, 8'd255, 8'd0, 8'd0,
               8'd0,   8'd255, 8'd0, 8'd0,
               8'd200, 8'd9,   8'd1, 8'd2,
               8'd9,   8'd9,   8'd7, 8'd4};
        ex = '{8'd255, 8'd0, 8'd200, 8'd7};
        frame(1'b0);
        idle();

`ifdef STREAM_POOL_AVG_EN
        pool_mode = 1'b1;
        for (int i = 0; i < 16; i++) px[i] = 8'(i);
        ex = '{8'd3, 8'd5, 8'd11, 8'd13};
        frame(1'b0);
        for (int i = 0; i < 16; i++) px[i] = 8'd255;
        ex = '{8'd255, 8'd255, 8'd255, 8'd255};
        frame(1'b0);
        idle();
        pool_mode = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/stream_pool2x2.md
Name: stream_pool2x2

Overview:
- Streaming 2x2, stride-2 pooling engine for raster-order pixel streams. It sits between a pixel source (camera or conv stage) and the next CNN layer.
- Generalises the fixed 8-bit, 8-wide max pooler in three ways: parametrised pixel width and image size, an in_valid qualifier that allows gaps in the stream, and explicit frame-end signalling.
- Produces one pooled pixel per 2x2 window, in raster order.

Parameters:
- DATA_W, 8: pixel width in bits. Pixels are unsigned.
- IMG_W, 8: pixels per row. Must be even and >= 2.
- IMG_H, 8: rows per frame. Must be even and >= 2.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  in_data carries a pixel this cycle
- in_data  in  DATA_W  input pixel, raster order
- out_valid  out  1  out_data carries a pooled pixel this cycle
- out_data  out  DATA_W  pooled pixel
- out_last  out  1  high with out_valid on the final pooled pixel of a frame

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, col=0, row=0, state=ROW_TOP. Line buffer and hold register are not cleared (contents are don't-care).
- Reset has priority over in_valid. Reset mid-frame discards the partial frame; the next accepted pixel is (row 0, col 0).
- A pixel is accepted only when in_valid=1. When in_valid=0, counters, buffers and state hold.
- There is no backpressure; the consumer must always accept.
- Counters:
  - col: 0..IMG_W-1, width $clog2(IMG_W).
  - row: 0..IMG_H-1.
  - col wraps to 0 after IMG_W-1 and increments row.
  - row wraps to 0 after IMG_H-1, so back-to-back frames need no idle cycle.
- FSM, 2 states, tracking row parity:
  - ROW_TOP (even row): each accepted pixel is written to linebuf[col]. Transition to ROW_BOT when col=IMG_W-1 is accepted.
  - ROW_BOT (odd row):
    - Even col: the pixel is stored in the hold register.
    - Odd col: the window {linebuf[col-1], linebuf[col], hold, in_data} is reduced.
    - Transition to ROW_TOP when col=IMG_W-1 is accepted.
- Latency: out_valid asserts exactly 1 cycle after the bottom-right pixel of a window is accepted. It is a single-cycle pulse per window.
- out_valid is high for exactly (IMG_W/2)*(IMG_H/2) cycles per frame.
- Reduction (max): unsigned maximum of the 4 pixels. Ties are irrelevant because the value is identical.
- out_last = 1 together with out_valid for the window whose bottom-right pixel is (IMG_H-1, IMG_W-1).
- out_data holds its last value when out_valid=0.
- Even IMG_W/IMG_H is enforced at elaboration; an odd value is a fatal elaboration error.

Optional Feature:
- Macro: STREAM_POOL_AVG_EN.
- Defined:
  - Adds input port pool_mode (1 bit), sampled with the bottom-right pixel. 0 selects max, 1 selects average.
  - Average = (p0+p1+p2+p3+2) >> 2, computed in DATA_W+2 bits and truncated to DATA_W. The result never overflows.
  - Latency is unchanged.
- Not defined: the port is absent and the block always computes max.

Decomposition:
- Package stream_pool_pkg:
  - state enum {ROW_TOP, ROW_BOT}
  - mode constants POOL_MAX=0, POOL_AVG=1
- One combinational sub-module, pool4_reduce:
  - Inputs: four DATA_W operands, plus mode when STREAM_POOL_AVG_EN is defined.
  - Output: the reduced value.
  - The top level registers its output.

Test Plan:
- IMG_W=4, IMG_H=4, DATA_W=8; pixels 0..15 back-to-back with in_valid=1 -> outputs 5,7,13,15, each 1 cycle after pixels 5,7,13,15; out_last only with 15.
- Same frame with in_valid low on every other cycle -> same values 5,7,13,15; out_valid count=4; each output 1 cycle after its bottom-right pixel.
- Two consecutive frames (0..15 then 15..0) -> first frame 5,7,13,15; second frame 15,13,7,5; out_last on the 4th and 8th outputs.
- Reset asserted after pixel 9, then full frame 0..15 -> no output from the aborted frame; outputs 5,7,13,15.
- DATA_W=8, window {255,255,0,255} -> 255; window {0,0,0,0} -> 0.
- STREAM_POOL_AVG_EN defined, pool_mode=1, pixels 0..15 -> outputs 3,5,11,13; window {255,255,255,255} -> 255.
